// File: rtl/apb_slave_mux.sv
// APB one-to-two slave mux: decodes the two slave windows and forwards responses combinationally, adding no latency.
// Slave pready stalls pass straight through; a stalled transfer ends with an error response after TIMEOUT_CYCLES.
module apb_slave_mux #(
    parameter int          ADDR_WIDTH     = 32,
    parameter int          DATA_WIDTH     = 32,
    parameter logic [31:0] SLV1_BASE      = 32'h0001_F000,
    parameter logic [31:0] SLV2_BASE      = 32'h0002_F000,
    parameter logic [31:0] WIN_SIZE       = 32'h0000_1000,
    parameter int          TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] paddr_i,
    input  logic [DATA_WIDTH-1:0] pwdata_i,
    input  logic                  pwrite_i,
    input  logic                  penable_i,
    input  logic [1:0]            psel_i,
    output logic [DATA_WIDTH-1:0] prdata_o,
    output logic                  pready_o,
    output logic                  pslverr_o,
    output logic [ADDR_WIDTH-1:0] s_paddr_o,
    output logic [DATA_WIDTH-1:0] s_pwdata_o,
    output logic                  s_pwrite_o,
    output logic                  s_penable_o,
    output logic                  s1_psel_o,
    output logic                  s2_psel_o,
    input  logic [DATA_WIDTH-1:0] s1_prdata_i,
    input  logic [DATA_WIDTH-1:0] s2_prdata_i,
    input  logic                  s1_pready_i,
    input  logic                  s2_pready_i,
    input  logic                  s1_pslverr_i,
    input  logic                  s2_pslverr_i,
    output logic                  timeout_o,
    output logic [7:0]            err_cnt_o
);
    typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_ACCESS, ST_ABORT} state_e;
    typedef enum logic [1:0] {TGT_NONE, TGT_S1, TGT_S2} tgt_e;

    localparam logic [ADDR_WIDTH-1:0] S1_LO    = ADDR_WIDTH'(SLV1_BASE);
    localparam logic [ADDR_WIDTH-1:0] S2_LO    = ADDR_WIDTH'(SLV2_BASE);
    localparam logic [ADDR_WIDTH-1:0] WIN      = ADDR_WIDTH'(WIN_SIZE);
    localparam logic [7:0]            TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_e                state_q, state_d, cur_st;
    tgt_e                  tgt_q, tgt_d, dec_tgt;
    logic [7:0]            timer_q, timer_d;
    logic [7:0]            err_cnt_q, err_cnt_d;
    logic                  done_q, done_d;
    logic                  req, viol;
    logic                  slv_rdy, slv_err;
    logic [DATA_WIDTH-1:0] slv_rdata;
    logic                  sel1, sel2, s_pen, rdy, serr, tmo;
    logic [DATA_WIDTH-1:0] rdata;

    assign req = |psel_i;

    always_comb begin
        dec_tgt = TGT_NONE;
        if ((paddr_i >= S1_LO) && ((paddr_i - S1_LO) < WIN)) begin
            dec_tgt = TGT_S1;
        end else if ((paddr_i >= S2_LO) && ((paddr_i - S2_LO) < WIN)) begin
            dec_tgt = TGT_S2;
        end
    end

    // state_q holds last cycle's phase; the phase of the current cycle also depends on the
    // upstream inputs now, so the slave setup phase lines up with the bridge setup cycle.
    always_comb begin
        cur_st = state_q;
        viol   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    if (penable_i) viol = 1'b1;
                    else           cur_st = ST_SETUP;
                end
            end
            ST_SETUP:  cur_st = ST_ACCESS;
            ST_ACCESS: begin
                if (done_q) begin
                    if (!req)          cur_st = ST_IDLE;
                    else if (penable_i) cur_st = ST_ABORT;
                    else               cur_st = ST_SETUP;
                end
            end
            ST_ABORT: begin
                if (!req) cur_st = ST_IDLE;
            end
            default: cur_st = ST_IDLE;
        endcase
    end

    always_comb begin
        slv_rdy   = 1'b0;
        slv_err   = 1'b0;
        slv_rdata = '0;
        case (tgt_q)
            TGT_S1: begin
                slv_rdy   = s1_pready_i;
                slv_err   = s1_pslverr_i;
                slv_rdata = s1_prdata_i;
            end
            TGT_S2: begin
                slv_rdy   = s2_pready_i;
                slv_err   = s2_pslverr_i;
                slv_rdata = s2_prdata_i;
            end
            default: ;
        endcase
    end

    always_comb begin
        sel1    = 1'b0;
        sel2    = 1'b0;
        s_pen   = 1'b0;
        rdy     = 1'b0;
        serr    = 1'b0;
        tmo     = 1'b0;
        rdata   = '0;
        timer_d = timer_q;
        tgt_d   = tgt_q;
        done_d  = 1'b0;
        state_d = cur_st;
        case (cur_st)
            ST_IDLE: begin
                if (viol) begin
                    rdy     = 1'b1;
                    serr    = 1'b1;
                    state_d = ST_ABORT;
                end
            end
            ST_SETUP: begin
                sel1    = (dec_tgt == TGT_S1);
                sel2    = (dec_tgt == TGT_S2);
                tgt_d   = dec_tgt;
                timer_d = '0;
            end
            ST_ACCESS: begin
                if (tgt_q == TGT_NONE) begin
                    rdy  = 1'b1;
                    serr = 1'b1;
                end else if (!slv_rdy && (timer_q == TMO_LAST)) begin
                    // a slave ready on the limit cycle takes the branch below instead
                    rdy  = 1'b1;
                    serr = 1'b1;
                    tmo  = 1'b1;
                end else begin
                    sel1  = (tgt_q == TGT_S1);
                    sel2  = (tgt_q == TGT_S2);
                    s_pen = penable_i;
                    rdy   = slv_rdy;
                    serr  = slv_err;
                    rdata = slv_rdata;
                    if (!slv_rdy) timer_d = timer_q + 8'd1;
                end
                done_d = rdy;
            end
            default: ;
        endcase
        err_cnt_d = err_cnt_q;
        if (rdy && serr && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            tgt_q     <= TGT_NONE;
            timer_q   <= '0;
            err_cnt_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            tgt_q     <= tgt_d;
            timer_q   <= timer_d;
            err_cnt_q <= err_cnt_d;
            done_q    <= done_d;
        end
    end

    // Reset silences every combinational path in the same cycle, including the broadcast bus.
    assign s1_psel_o   = sel1 & ~rst;
    assign s2_psel_o   = sel2 & ~rst;
    assign s_penable_o = s_pen & ~rst;
    assign pready_o    = rdy & ~rst;
    assign pslverr_o   = serr & ~rst;
    assign timeout_o   = tmo & ~rst;
    assign prdata_o    = rst ? '0 : rdata;
    assign s_paddr_o   = rst ? '0 : paddr_i;
    assign s_pwdata_o  = rst ? '0 : pwdata_i;
    assign s_pwrite_o  = pwrite_i & ~rst;
    assign err_cnt_o   = err_cnt_q;

endmodule

// File: tb/tb_apb_slave_mux.sv
// Bench for apb_slave_mux: vector table, directed corner sequences and randomized transfers against a transfer-level model.
module tb_apb_slave_mux;
    localparam int          TMO  = 16;
    localparam logic [31:0] S1B  = 32'h0001_F000;
    localparam logic [31:0] S2B  = 32'h0002_F000;
    localparam logic [31:0] WIN  = 32'h0000_1000;
    localparam logic [31:0] JUNK = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] paddr_i, pwdata_i, prdata_o, s_paddr_o, s_pwdata_o;
    logic        pwrite_i, penable_i, pready_o, pslverr_o, s_pwrite_o, s_penable_o;
    logic [1:0]  psel_i;
    logic        s1_psel_o, s2_psel_o, timeout_o;
    logic [31:0] s1_prdata_i, s2_prdata_i;
    logic        s1_pready_i, s2_pready_i, s1_pslverr_i, s2_pslverr_i;
    logic [7:0]  err_cnt_o;

    apb_slave_mux #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .SLV1_BASE(S1B), .SLV2_BASE(S2B),
        .WIN_SIZE(WIN), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .rst(rst), .paddr_i(paddr_i), .pwdata_i(pwdata_i), .pwrite_i(pwrite_i),
        .penable_i(penable_i), .psel_i(psel_i), .prdata_o(prdata_o), .pready_o(pready_o),
        .pslverr_o(pslverr_o), .s_paddr_o(s_paddr_o), .s_pwdata_o(s_pwdata_o),
        .s_pwrite_o(s_pwrite_o), .s_penable_o(s_penable_o), .s1_psel_o(s1_psel_o),
        .s2_psel_o(s2_psel_o), .s1_prdata_i(s1_prdata_i), .s2_prdata_i(s2_prdata_i),
        .s1_pready_i(s1_pready_i), .s2_pready_i(s2_pready_i), .s1_pslverr_i(s1_pslverr_i),
        .s2_pslverr_i(s2_pslverr_i), .timeout_o(timeout_o), .err_cnt_o(err_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [31:0] wdata;
        int          wt;
        logic        serr;
        logic [31:0] rdata;
        bit          retgt;
        int          tgt;
        int          ncyc;
        logic        err;
        logic        tmo;
        logic [31:0] prd;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  exp_cnt;
    vec_t        tbl[10];
    vec_t        rv;
    logic [31:0] ra;
    int          rwt;
    logic [31:0] edges[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input logic e1, input logic e2, input logic ep,
                            input logic er, input logic ee, input logic [31:0] ed, input logic et);
        chk({tag, " s1_psel"}, 32'(s1_psel_o), 32'(e1));
        chk({tag, " s2_psel"}, 32'(s2_psel_o), 32'(e2));
        chk({tag, " s_penable"}, 32'(s_penable_o), 32'(ep));
        chk({tag, " pready"}, 32'(pready_o), 32'(er));
        chk({tag, " pslverr"}, 32'(pslverr_o), 32'(ee));
        chk({tag, " prdata"}, prdata_o, ed);
        chk({tag, " timeout"}, 32'(timeout_o), 32'(et));
        chk({tag, " err_cnt"}, 32'(err_cnt_o), 32'(exp_cnt));
        chk({tag, " s_paddr"}, s_paddr_o, paddr_i);
        chk({tag, " s_pwdata"}, s_pwdata_o, pwdata_i);
        chk({tag, " s_pwrite"}, 32'(s_pwrite_o), 32'(pwrite_i));
        if (er && ee && exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'd1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " s1_psel"}, 32'(s1_psel_o), 0);
        chk({tag, " s2_psel"}, 32'(s2_psel_o), 0);
        chk({tag, " s_penable"}, 32'(s_penable_o), 0);
        chk({tag, " pready"}, 32'(pready_o), 0);
        chk({tag, " pslverr"}, 32'(pslverr_o), 0);
        chk({tag, " prdata"}, prdata_o, 0);
        chk({tag, " timeout"}, 32'(timeout_o), 0);
        chk({tag, " err_cnt"}, 32'(err_cnt_o), 0);
        chk({tag, " s_paddr"}, s_paddr_o, 0);
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_slaves(input logic r1, input logic e1, input logic [31:0] d1,
                              input logic r2, input logic e2, input logic [31:0] d2);
        s1_pready_i = r1; s1_pslverr_i = e1; s1_prdata_i = d1;
        s2_pready_i = r2; s2_pslverr_i = e2; s2_prdata_i = d2;
    endtask

    // Expected outcome of one transfer, from the address windows and the slave's wait count.
    function automatic vec_t model(input logic [31:0] a, input logic wr, input int wt,
                                   input logic serr, input logic [31:0] rd);
        vec_t v;
        v.addr = a; v.wr = wr; v.wdata = rd ^ 32'hFFFF_0000; v.wt = wt;
        v.serr = serr; v.rdata = rd; v.retgt = 1'b0;
        if (a >= S1B && (a - S1B) < WIN)      v.tgt = 1;
        else if (a >= S2B && (a - S2B) < WIN) v.tgt = 2;
        else                                  v.tgt = 0;
        if (v.tgt == 0) begin
            v.ncyc = 1; v.err = 1'b1; v.tmo = 1'b0; v.prd = 32'h0;
        end else if (wt < TMO) begin
            v.ncyc = wt + 1; v.err = serr; v.tmo = 1'b0; v.prd = rd;
        end else begin
            v.ncyc = TMO; v.err = 1'b1; v.tmo = 1'b1; v.prd = 32'h0;
        end
        return v;
    endfunction

    task automatic run_xfer(input vec_t v);
        logic        tr, last, sel;
        logic [31:0] rdv;
        next_cyc();
        psel_i = 2'($urandom_range(1, 3));
        penable_i = 1'b0; paddr_i = v.addr; pwdata_i = v.wdata; pwrite_i = v.wr;
        set_slaves(1'b1, 1'b1, JUNK, 1'b1, 1'b1, JUNK);
        #3 chk_outs("setup", v.tgt == 1, v.tgt == 2, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        for (int k = 1; k <= v.ncyc; k++) begin
            next_cyc();
            penable_i = 1'b1;
            if (v.retgt) paddr_i = (v.tgt == 1) ? S2B + 32'h20 : S1B + 32'h20;
            tr = (k > v.wt);
            set_slaves(v.tgt == 1 ? tr : 1'b1, v.tgt == 1 ? (tr & v.serr) : 1'b0, v.tgt == 1 ? v.rdata : JUNK,
                       v.tgt == 2 ? tr : 1'b1, v.tgt == 2 ? (tr & v.serr) : 1'b0, v.tgt == 2 ? v.rdata : JUNK);
            last = (k == v.ncyc);
            sel  = (v.tgt != 0) && !(last && v.tmo);
            rdv  = last ? v.prd : ((v.tgt != 0) ? v.rdata : 32'h0);
            #3 chk_outs("access", sel && v.tgt == 1, sel && v.tgt == 2, sel, last,
                        last ? v.err : 1'b0, rdv, last && v.tmo);
        end
    endtask

    task automatic idle_cyc(input int n);
        for (int i = 0; i < n; i++) begin
            next_cyc();
            psel_i = 2'b00; penable_i = 1'b0; paddr_i = $urandom; pwdata_i = $urandom;
            set_slaves(1'b1, 1'b1, JUNK, 1'b1, 1'b1, JUNK);
            #3 chk_outs("idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not end");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{32'h0001_F004, 1'b1, 32'hA5A5_A5A5, 0, 1'b0, 32'h1111_0000, 1'b0, 1, 1, 1'b0, 1'b0, 32'h1111_0000};
        tbl[1] = '{32'h0002_F010, 1'b0, 32'h0, 3, 1'b0, 32'h1234_5678, 1'b1, 2, 4, 1'b0, 1'b0, 32'h1234_5678};
        tbl[2] = '{32'h0003_0000, 1'b0, 32'h0, 0, 1'b0, 32'h5555_5555, 1'b0, 0, 1, 1'b1, 1'b0, 32'h0};
        tbl[3] = '{32'h0001_F000, 1'b0, 32'h0, 20, 1'b0, 32'h7777_7777, 1'b0, 1, 16, 1'b1, 1'b1, 32'h0};
        tbl[4] = '{32'h0002_F000, 1'b0, 32'h0, 15, 1'b0, 32'h3333_4444, 1'b0, 2, 16, 1'b0, 1'b0, 32'h3333_4444};
        tbl[5] = '{32'h0001_FFFC, 1'b1, 32'hCAFE_0001, 2, 1'b1, 32'h0000_00EE, 1'b0, 1, 3, 1'b1, 1'b0, 32'h0000_00EE};
        tbl[6] = '{32'h0001_EFFC, 1'b0, 32'h0, 0, 1'b0, 32'h0000_0009, 1'b0, 0, 1, 1'b1, 1'b0, 32'h0};
        tbl[7] = '{32'h0002_0000, 1'b0, 32'h0, 0, 1'b0, 32'h0000_0009, 1'b0, 0, 1, 1'b1, 1'b0, 32'h0};
        tbl[8] = '{32'h0002_FFFC, 1'b0, 32'h0, 1, 1'b0, 32'hABCD_EF01, 1'b0, 2, 2, 1'b0, 1'b0, 32'hABCD_EF01};
        tbl[9] = '{32'h0002_EFFF, 1'b1, 32'h0000_0001, 0, 1'b0, 32'h0000_0002, 1'b0, 0, 1, 1'b1, 1'b0, 32'h0};
        edges[0] = S1B; edges[1] = S1B + WIN - 1; edges[2] = S1B + WIN;
        edges[3] = S2B - 1; edges[4] = S2B + WIN - 1; edges[5] = S2B + WIN;

        // reset with an illegal enable-without-setup on the inputs: everything must stay quiet
        rst = 1'b1; exp_cnt = 8'h00;
        psel_i = 2'b11; penable_i = 1'b1; paddr_i = S1B; pwdata_i = 32'h0; pwrite_i = 1'b1;
        set_slaves(1'b1, 1'b1, JUNK, 1'b1, 1'b1, JUNK);
        #12 chk_zero("reset");
        next_cyc();
        rst = 1'b0; psel_i = 2'b00; penable_i = 1'b0; pwrite_i = 1'b0;
        #3 chk_outs("reset_release", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);

        for (int i = 0; i < 10; i++) begin
            run_xfer(tbl[i]);
            if (i % 3 == 2) idle_cyc(1);
        end
        idle_cyc(1);

        // timeout, upstream holds the request, then a new setup while still held is ignored
        run_xfer(model(S1B + 32'h40, 1'b0, 30, 1'b0, 32'h0000_0001));
        for (int i = 0; i < 2; i++) begin
            next_cyc();
            psel_i = 2'b01; penable_i = 1'b1;
            #3 chk_outs("abort_hold", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        end
        next_cyc();
        penable_i = 1'b0; paddr_i = S1B;
        #3 chk_outs("abort_setup", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        idle_cyc(1);
        run_xfer(model(S2B + 32'h8, 1'b0, 1, 1'b0, 32'h0000_600D));

        // enable without setup from idle
        idle_cyc(1);
        next_cyc();
        psel_i = 2'b10; penable_i = 1'b1; paddr_i = S1B + 32'h4;
        #3 chk_outs("viol", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0, 1'b0);
        next_cyc();
        #3 chk_outs("viol_abort", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        idle_cyc(1);
        run_xfer(model(S1B + 32'h10, 1'b1, 0, 1'b0, 32'h0000_0042));

        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 3))
                0:       ra = S1B + 32'($urandom_range(0, 1023)) * 4;
                1:       ra = S2B + 32'($urandom_range(0, 1023)) * 4;
                2:       ra = $urandom;
                default: ra = edges[$urandom_range(0, 5)];
            endcase
            rwt = ($urandom_range(0, 7) == 0) ? int'($urandom_range(14, 18)) : int'($urandom_range(0, 4));
            rv = model(ra, 1'($urandom_range(0, 1)), rwt, 1'($urandom_range(0, 1)), $urandom);
            if ($urandom_range(0, 3) == 0) rv.retgt = 1'b1;
            run_xfer(rv);
            idle_cyc(int'($urandom_range(0, 2)));
        end

        // reset in the middle of a stalled access
        idle_cyc(1);
        next_cyc();
        psel_i = 2'b01; penable_i = 1'b0; paddr_i = S2B; pwrite_i = 1'b0;
        set_slaves(1'b1, 1'b0, JUNK, 1'b0, 1'b0, 32'h0000_BEEF);
        #3 chk_outs("rst_setup", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        next_cyc();
        penable_i = 1'b1;
        #3 chk_outs("rst_access", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_BEEF, 1'b0);
        rst = 1'b1;
        #1 chk_zero("rst_mid_access");
        exp_cnt = 8'h00;
        next_cyc();
        rst = 1'b0; psel_i = 2'b00; penable_i = 1'b0;
        #3 chk_outs("post_rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        run_xfer(model(S2B + 32'h100, 1'b0, 2, 1'b0, 32'h0BAD_CAFE));

        // 256 decode errors from a cleared counter
        for (int n = 0; n < 256; n++) run_xfer(model(32'h0004_0000 + 32'(n) * 4, 1'b0, 0, 1'b0, 32'h0));
        idle_cyc(1);
        chk("err_cnt_saturated", 32'(err_cnt_o), 32'h0000_00FF);
        run_xfer(model(32'h0005_0000, 1'b0, 0, 1'b0, 32'h0));
        idle_cyc(1);
        chk("err_cnt_held", 32'(err_cnt_o), 32'h0000_00FF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/apb_slave_mux.md
APB_SLAVE_MUX -- requirements
Module: apb_slave_mux

Interface
REQ-001 SHALL have parameters: ADDR_WIDTH, 32, address width; DATA_WIDTH, 32, data width; SLV1_BASE, 32'h0001_F000, slave-1 window base; SLV2_BASE, 32'h0002_F000, slave-2 window base; WIN_SIZE, 32'h0000_1000, window size; TIMEOUT_CYCLES, 16, max ACCESS cycles (range 2-255).
REQ-002 SHALL use one clock and an asynchronous, active-high reset; ports clk and rst.
REQ-003 SHALL have the following ports (name, direction, width, meaning):
- clk, in, 1, clock.
- rst, in, 1, async active-high reset.
- paddr_i, in, ADDR_WIDTH, upstream bridge address.
- pwdata_i, in, DATA_WIDTH, upstream write data.
- pwrite_i, in, 1, upstream direction.
- penable_i, in, 1, upstream enable.
- psel_i, in, 2, upstream select; any bit set means request.
- prdata_o, out, DATA_WIDTH, read data to bridge.
- pready_o, out, 1, ready to bridge.
- pslverr_o, out, 1, error to bridge.
- s_paddr_o, out, ADDR_WIDTH, broadcast to slaves.
- s_pwdata_o, out, DATA_WIDTH, broadcast to slaves.
- s_pwrite_o, out, 1, broadcast to slaves.
- s_penable_o, out, 1, broadcast to slaves.
- s1_psel_o, out, 1, slave-1 select.
- s2_psel_o, out, 1, slave-2 select.
- s1_prdata_i / s2_prdata_i, in, DATA_WIDTH, slave read data.
- s1_pready_i / s2_pready_i, in, 1, slave ready.
- s1_pslverr_i / s2_pslverr_i, in, 1, slave error.
- timeout_o, out, 1, one-cycle pulse on timeout.
- err_cnt_o, out, 8, saturating error count.

Function
REQ-004 SHALL decode the target from paddr_i only: SLV1 if SLV1_BASE <= paddr_i < SLV1_BASE+WIN_SIZE; SLV2 likewise; otherwise NONE. psel_i bit pattern is ignored beyond "nonzero".
REQ-005 SHALL run a registered FSM with states IDLE, SETUP, ACCESS, ABORT:
- IDLE->SETUP on req & !penable_i.
- SETUP->ACCESS unconditionally.
- ACCESS->IDLE on completion with !req.
- ACCESS->SETUP on completion with req & !penable_i.
- ACCESS->ABORT on timeout when upstream keeps req & penable_i next cycle.
- ABORT->IDLE when !req.
REQ-006 SHALL latch the target at the IDLE/ACCESS->SETUP transition and hold it through ACCESS; the address change in ACCESS SHALL NOT retarget.
REQ-007 SHALL drive sN_psel_o combinationally in SETUP-phase cycles (req & !penable_i, decoded target=N) and from the latched target in ACCESS; 0 in IDLE, ABORT, and for target NONE.
REQ-008 SHALL pass s_paddr_o, s_pwdata_o, s_pwrite_o combinationally from upstream; s_penable_o = penable_i only in ACCESS with target != NONE, else 0.
REQ-009 In ACCESS, SHALL forward prdata_o/pready_o/pslverr_o from the latched slave; other cycles pready_o=0, pslverr_o=0, prdata_o=0.
REQ-010 Target NONE: SHALL complete in the first ACCESS cycle with pready_o=1, pslverr_o=1, prdata_o=0 (zero wait states).
REQ-011 SHALL count ACCESS cycles with slave pready low in 8-bit timer, cleared on SETUP; when timer == TIMEOUT_CYCLES-1 and slave pready still 0: pready_o=1, pslverr_o=1, prdata_o=0, timeout_o=1, s_penable_o and sN_psel_o forced 0 that cycle.
REQ-012 Slave pready=1 in the same cycle as the timeout limit SHALL win (normal completion, no timeout).
REQ-013 Protocol violation (penable_i=1 with req while in IDLE, i.e. no SETUP): SHALL not select any slave, respond pready_o=1, pslverr_o=1 same cycle, then enter ABORT.
REQ-014 err_cnt_o SHALL increment by 1 on every cycle with pready_o & pslverr_o (decode, timeout, violation, slave error), saturating at 8'hFF.
REQ-015 Back-to-back transfers (SETUP immediately after completion) SHALL incur no idle cycle.

Reset
REQ-016 On rst=1, asynchronously: FSM=IDLE, timer=0, latched target=NONE, err_cnt_o=0, timeout_o=0, pready_o=0, pslverr_o=0, prdata_o=0, s1/s2_psel_o=0, s_penable_o=0.
REQ-017 Reset mid-ACCESS SHALL drop all selects immediately; no completion is reported for the aborted transfer.

Verification
REQ-018 Write 0x0001_F004 data 0xA5A5_A5A5, s1 ready in 1st ACCESS -> s1_psel_o for 2 cycles, s2_psel_o=0, pslverr_o=0, err_cnt_o=0.
REQ-019 Read 0x0002_F010, s2 waits 3 cycles then ready with prdata 0x1234_5678 -> prdata_o=0x1234_5678 with pready_o on 4th ACCESS cycle.
REQ-020 Read 0x0003_0000 -> no slave selected, pready_o=1, pslverr_o=1 in 1st ACCESS, err_cnt_o=1.
REQ-021 s1 never ready, TIMEOUT_CYCLES=16 -> pready_o=1, pslverr_o=1, timeout_o=1 on 16th ACCESS cycle; s1_psel_o=0 that cycle.
REQ-022 Enable without SETUP at IDLE -> immediate error response, ABORT until psel_i=0; then a legal transfer completes normally.
REQ-023 256 decode-error transfers -> err_cnt_o holds 8'hFF; rst mid-ACCESS -> all outputs 0 within the same cycle.
